// File: rtl/mtr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_pkg
// Purpose  : Shared types, constants and the speed-to-duty helper for the
//            motor drive stage.
// Revision : 1.0  initial release
// ============================================================================
package mtr_drv_pkg;

    localparam int PWM_W = 11;

    // 50% duty; also the value the duty registers hold out of reset
    localparam logic [PWM_W-1:0] DUTY_MID = 11'h400;

    // Last count of a PWM period; duty capture and period_wrap happen here
    localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};

    typedef logic signed [10:0] spd_t;
    typedef logic [PWM_W-1:0]   duty_t;

    // Signed speed to offset-binary duty: adding 1024 is just a sign-bit flip,
    // and the full input range maps onto the full duty range without clipping.
    function automatic duty_t spd2duty(input spd_t spd);
        return {~spd[10], spd[9:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_drv_pwm_nonoverlap.sv
`default_nettype none
// ============================================================================
// Module   : pwm_nonoverlap
// Purpose  : Turns one raw PWM level into a complementary high/low-side pair
//            with a programmable dead time after every edge.
// Revision : 1.0  initial release
// ============================================================================
module pwm_nonoverlap #(
    parameter int NONOVERLAP = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sig,
    output logic pwm1,
    output logic pwm2
);

    localparam int              DT_W   = $clog2(NONOVERLAP + 1);
    localparam logic [DT_W-1:0] DT_MAX = DT_W'(NONOVERLAP);

    logic            sig_prev_q, sig_prev_d;
    logic            en_q,       en_d;
    logic [DT_W-1:0] dt_q,       dt_d;
    logic            pwm1_q,     pwm1_d;
    logic            pwm2_q,     pwm2_d;
    logic            w_restart;

    // Dead-time sequencing: any edge on sig, or a disable (including the
    // first cycle back from one), drops both outputs and restarts the count.
    // Outputs only ever take sig/~sig, so they can never both be high.
    always_comb begin
        sig_prev_d = sig;
        en_d       = en;
        dt_d       = dt_q;
        pwm1_d     = pwm1_q;
        pwm2_d     = pwm2_q;
        w_restart  = !en || !en_q || (sig != sig_prev_q);

        if (w_restart) begin
            dt_d   = '0;
            pwm1_d = 1'b0;
            pwm2_d = 1'b0;
        end else if (dt_q != DT_MAX) begin
            dt_d = dt_q + DT_W'(1);
            if (dt_d == DT_MAX) begin
                pwm1_d = sig;
                pwm2_d = ~sig;
            end
        end else begin
            pwm1_d = sig;
            pwm2_d = ~sig;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_prev_q <= 1'b0;
            en_q       <= 1'b0;
            dt_q       <= '0;
            pwm1_q     <= 1'b0;
            pwm2_q     <= 1'b0;
        end else begin
            sig_prev_q <= sig_prev_d;
            en_q       <= en_d;
            dt_q       <= dt_d;
            pwm1_q     <= pwm1_d;
            pwm2_q     <= pwm2_d;
        end
    end

    assign pwm1 = pwm1_q;
    assign pwm2 = pwm2_q;

endmodule
`default_nettype wire

// File: rtl/mtr_drv.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv
// Purpose  : Motor drive stage. Converts signed left/right wheel speeds into
//            two dead-time protected complementary PWM pairs. Duty changes
//            are captured only at the period boundary.
// Revision : 1.0  initial release
// ============================================================================
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        lft_pwm1,
    output logic        lft_pwm2,
    output logic        rght_pwm1,
    output logic        rght_pwm2,
    output logic        period_wrap
);

    duty_t cnt_q,       cnt_d;
    duty_t lft_duty_q,  lft_duty_d;
    duty_t rght_duty_q, rght_duty_d;
    logic  lft_sig_q,   lft_sig_d;
    logic  rght_sig_q,  rght_sig_d;
    logic  w_wrap;

    assign w_wrap      = (cnt_q == CNT_MAX);
    assign period_wrap = w_wrap;

    // Counter, boundary-only duty capture and registered comparators.
    // These keep running while disabled so re-enabling stays in phase.
    always_comb begin
        cnt_d       = cnt_q + duty_t'(1);
        lft_duty_d  = lft_duty_q;
        rght_duty_d = rght_duty_q;
        if (w_wrap) begin
            lft_duty_d  = spd2duty(spd_t'(lft_spd));
            rght_duty_d = spd2duty(spd_t'(rght_spd));
        end
        lft_sig_d  = (cnt_q < lft_duty_q);
        rght_sig_d = (cnt_q < rght_duty_q);
    end

    // Period state registers; reset aborts the current period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            lft_duty_q  <= DUTY_MID;
            rght_duty_q <= DUTY_MID;
            lft_sig_q   <= 1'b0;
            rght_sig_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lft_duty_q  <= lft_duty_d;
            rght_duty_q <= rght_duty_d;
            lft_sig_q   <= lft_sig_d;
            rght_sig_q  <= rght_sig_d;
        end
    end

    pwm_nonoverlap #(
        .NONOVERLAP (NONOVERLAP)
    ) u_lft_nonoverlap (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .sig   (lft_sig_q),
        .pwm1  (lft_pwm1),
        .pwm2  (lft_pwm2)
    );

    pwm_nonoverlap #(
        .NONOVERLAP (NONOVERLAP)
    ) u_rght_nonoverlap (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .sig   (rght_sig_q),
        .pwm1  (rght_pwm1),
        .pwm2  (rght_pwm2)
    );

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtr_drv
// Purpose  : Directed self-checking bench for mtr_drv.
// Revision : 1.0  initial release
// ============================================================================
module tb_mtr_drv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, period_wrap;

    int     checks = 0;
    int     errors = 0;
    bit     mon_on = 1'b0;
    longint cyc = 0;
    longint last_wrap = 0;
    bit     have_wrap = 1'b0;

    int l1, l2, r1, r2, lowl, lowr, wraps;

    mtr_drv #(.NONOVERLAP(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .lft_spd     (lft_spd),
        .rght_spd    (rght_spd),
        .lft_pwm1    (lft_pwm1),
        .lft_pwm2    (lft_pwm2),
        .rght_pwm1   (rght_pwm1),
        .rght_pwm2   (rght_pwm2),
        .period_wrap (period_wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Continuous properties: no shoot-through, one wrap every 2048 clocks
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            assert (!(lft_pwm1 && lft_pwm2)) else begin
                errors++;
                $error("FAIL lft_overlap: observed=1 expected=0");
            end
            checks++;
            assert (!(rght_pwm1 && rght_pwm2)) else begin
                errors++;
                $error("FAIL rght_overlap: observed=1 expected=0");
            end
            if (!rst_n) begin
                have_wrap = 1'b0;
            end else if (period_wrap) begin
                if (have_wrap) begin
                    checks++;
                    assert (cyc - last_wrap == 2048) else begin
                        errors++;
                        $error("FAIL wrap_interval: observed=%0d expected=2048", cyc - last_wrap);
                    end
                end
                have_wrap = 1'b1;
                last_wrap = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (int'(dut.cnt_q) != v && n < 4096) begin
            tick();
            n++;
        end
        if (n >= 4096) chk("wait_cnt_timeout", int'(dut.cnt_q), v);
    endtask

    task automatic measure();
        l1 = 0; l2 = 0; r1 = 0; r2 = 0; lowl = 0; lowr = 0; wraps = 0;
        repeat (2048) begin
            tick();
            l1    += int'(lft_pwm1);
            l2    += int'(lft_pwm2);
            r1    += int'(rght_pwm1);
            r2    += int'(rght_pwm2);
            lowl  += int'(!lft_pwm1 && !lft_pwm2);
            lowr  += int'(!rght_pwm1 && !rght_pwm2);
            wraps += int'(period_wrap);
        end
    endtask

    initial begin
        int n;

        // Reset
        rst_n = 1'b0; en = 1'b0; lft_spd = 11'h000; rght_spd = 11'h000;
        repeat (3) tick();
        chk("rst_lft_pwm1",  lft_pwm1,  0);
        chk("rst_lft_pwm2",  lft_pwm2,  0);
        chk("rst_rght_pwm1", rght_pwm1, 0);
        chk("rst_rght_pwm2", rght_pwm2, 0);
        chk("rst_wrap",      period_wrap, 0);
        chk("rst_cnt",       int'(dut.cnt_q), 0);
        chk("rst_lft_duty",  int'(dut.lft_duty_q), 'h400);
        chk("rst_rght_duty", int'(dut.rght_duty_q), 'h400);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // 50% on both sides
        en = 1'b1;
        repeat (2048) tick();
        measure();
        chk("mid_lft_pwm1_hi",  l1, 992);
        chk("mid_lft_pwm2_hi",  l2, 992);
        chk("mid_rght_pwm1_hi", r1, 992);
        chk("mid_rght_pwm2_hi", r2, 992);
        chk("mid_lft_deadtime", lowl, 64);
        chk("mid_rght_deadtime", lowr, 64);
        chk("mid_wraps",        wraps, 1);

        // Full reverse on the left
        lft_spd = 11'h400;
        repeat (4096) tick();
        measure();
        chk("rev_lft_pwm1_hi", l1, 0);
        chk("rev_lft_pwm2_hi", l2, 2048);
        chk("rev_rght_pwm1_hi", r1, 992);
        chk("rev_rght_pwm2_hi", r2, 992);

        // Full forward on the left: one-clock low gap stretched to 33
        lft_spd = 11'h3FF;
        repeat (4096) tick();
        measure();
        chk("fwd_lft_pwm1_hi", l1, 2015);
        chk("fwd_lft_pwm2_hi", l2, 0);
        chk("fwd_lft_low",     lowl, 33);

        // Mid-period speed change is deferred to the next period
        lft_spd = 11'h000;
        repeat (4096) tick();
        wait_cnt(700);
        lft_spd = 11'h200;
        wait_cnt(1200);
        chk("chg_cur_lft_pwm1", lft_pwm1, 0);
        chk("chg_cur_lft_pwm2", lft_pwm2, 1);
        wait_cnt(2047);
        chk("chg_duty_before_wrap", int'(dut.lft_duty_q), 'h400);
        chk("chg_wrap_pulse", period_wrap, 1);
        tick();
        chk("chg_duty_after_wrap", int'(dut.lft_duty_q), 'h600);
        wait_cnt(1500);
        chk("chg_next_lft_pwm1", lft_pwm1, 1);
        measure();
        chk("chg_lft_pwm1_hi",  l1, 1504);
        chk("chg_lft_pwm2_hi",  l2, 480);
        chk("chg_rght_pwm1_hi", r1, 992);
        chk("chg_rght_pwm2_hi", r2, 992);

        // Enable drop during the high phase
        lft_spd = 11'h000;
        repeat (4096) tick();
        wait_cnt(500);
        chk("en_pre_lft_pwm1", lft_pwm1, 1);
        en = 1'b0;
        tick();
        chk("en_off_lft_pwm1",  lft_pwm1,  0);
        chk("en_off_lft_pwm2",  lft_pwm2,  0);
        chk("en_off_rght_pwm1", rght_pwm1, 0);
        chk("en_off_rght_pwm2", rght_pwm2, 0);
        repeat (9) tick();
        en = 1'b1;
        n = 0;
        while (!lft_pwm1 && n < 100) begin
            tick();
            n++;
        end
        chk("en_reassert_delay", n, 33);
        chk("en_rght_pwm1",      rght_pwm1, 1);
        chk("en_cnt_undisturbed", int'(dut.cnt_q), 543);

        // Reset mid-period
        lft_spd = 11'h200;
        repeat (4096) tick();
        wait_cnt(1500);
        chk("mrst_pre_duty", int'(dut.lft_duty_q), 'h600);
        lft_spd = 11'h000;
        rst_n   = 1'b0;
        tick();
        chk("mrst_lft_pwm1",  lft_pwm1,  0);
        chk("mrst_lft_pwm2",  lft_pwm2,  0);
        chk("mrst_rght_pwm1", rght_pwm1, 0);
        chk("mrst_rght_pwm2", rght_pwm2, 0);
        chk("mrst_wrap",      period_wrap, 0);
        chk("mrst_cnt",       int'(dut.cnt_q), 0);
        chk("mrst_lft_duty",  int'(dut.lft_duty_q), 'h400);
        chk("mrst_rght_duty", int'(dut.rght_duty_q), 'h400);
        rst_n = 1'b1;
        repeat (2048) tick();
        measure();
        chk("mrst_lft_pwm1_hi",  l1, 992);
        chk("mrst_lft_pwm2_hi",  l2, 992);
        chk("mrst_rght_pwm1_hi", r1, 992);
        chk("mrst_wraps",        wraps, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
